// File: rtl/gray_chk_pkg.sv
// Shared types and helpers for the Gray step checker.
package gray_chk_pkg;

    typedef enum logic [1:0] {INIT, ACQ, LOCKED} state_t;
    typedef enum logic [1:0] {HOLD, GOOD, BAD} step_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign b[i] = ^g[N-1:i];
    end

endmodule

// File: rtl/gray_step_checker.sv
// Samples a Gray count, converts it to binary over two stages and flags illegal steps.
// Optional saturating error counter enabled by defining GRAY_STEP_ERR_CNT_EN.
module gray_step_checker
    import gray_chk_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [N-1:0]     gray_in,
    output logic [N-1:0]     bin_out,
    output logic             bin_valid,
    output logic             wrap,
    output logic             step_err,
    output logic             lock,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    logic [N-1:0]     g_p1;
    logic [N-1:0]     g_prev_p1;
    logic             vld_p1;
    logic [N-1:0]     bin_new;
    logic [N-1:0]     bin_inc;
    logic [N-1:0]     diff;
    step_t            step_cls;
    state_t           state;
    state_t           state_nx;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nx;
    logic             step_err_d;
    logic             wrap_d;

    // Stage 1: capture the sample and keep the previous one as the step reference
    always_ff @(posedge clk) begin
        if (rst) begin
            g_p1      <= '0;
            g_prev_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= clk_en;
            if (clk_en) begin
                g_p1      <= gray_in;
                g_prev_p1 <= g_p1;
            end
        end
    end

    gray_to_bin #(.N(N)) u_g2b (
        .g (g_p1),
        .b (bin_new)
    );

    // bin_out always holds the binary of the previous sample, so it serves as p
    always_comb begin
        diff     = g_p1 ^ g_prev_p1;
        bin_inc  = bin_out + N'(1);
        step_cls = BAD;
        if (diff == '0) begin
            step_cls = HOLD;
        end else if (popcount(32'(diff)) == 1 && bin_new == bin_inc) begin
            step_cls = GOOD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            run   <= '0;
        end else begin
            state <= state_nx;
            run   <= run_nx;
        end
    end

    always_comb begin
        state_nx = state;
        run_nx   = run;
        if (vld_p1) begin
            case (state)
                INIT: begin
                    state_nx = ACQ;
                    run_nx   = '0;
                end
                ACQ: begin
                    if (step_cls == GOOD) begin
                        run_nx = run + RUN_W'(1);
                        if (run == RUN_W'(LOCK_CNT - 1)) state_nx = LOCKED;
                    end else if (step_cls == BAD) begin
                        run_nx = '0;
                    end
                end
                LOCKED: begin
                    if (step_cls == GOOD) begin
                        if (run != RUN_W'(LOCK_CNT)) run_nx = run + RUN_W'(1);
                    end else if (step_cls == BAD) begin
                        run_nx   = '0;
                        state_nx = ACQ;
                    end
                end
                default: begin
                    state_nx = INIT;
                    run_nx   = '0;
                end
            endcase
        end
    end

    // A good step out of all-ones can only land on zero, so bin_out alone identifies a wrap
    always_comb begin
        step_err_d = vld_p1 && (state != INIT) && (step_cls == BAD);
        wrap_d     = vld_p1 && (state != INIT) && (step_cls == GOOD) && (bin_out == '1);
        lock       = (state == LOCKED);
    end

    // Stage 2: publish the converted value and the step verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out   <= '0;
            bin_valid <= 1'b0;
            wrap      <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            bin_valid <= vld_p1;
            wrap      <= wrap_d;
            step_err  <= step_err_d;
            if (vld_p1) bin_out <= bin_new;
        end
    end

`ifdef GRAY_STEP_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (step_err_d && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
